pclk_gen_divider: RTL

- Synthesizable divider in the TX clocking path, downstream of the PLL.
- Takes the serial bit clock (Bit_Rate, 5 GHz, 200 ps period) and generates two clocks: the symbol clock Bit_Rate_10 (÷10) and the PIPE parallel clock PCLK (÷10/÷20/÷40, selected by interface width).
- All generated clocks are phase-aligned, 50% duty and glitch-free across width changes.
- Clk_Valid tells downstream logic when the generated clocks are stable.

---
 rtl/pclk_gen_divider.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pclk_gen_divider.sv
`timescale 1ps/1ps
// pclk_gen_divider
// Derives the symbol clock (Bit_Rate/10) and the PIPE parallel clock PCLK
// (Bit_Rate/10, /20 or /40) from the serial bit clock. A 40-cycle phase
// frame (LCM of all divisors) keeps every output rising at cnt = 0, so ratio
// changes and restarts are applied only at the frame wrap and never produce
// a runt pulse. Clk_Valid reports a number of complete stable frames.
module pclk_gen_divider #(
    parameter int unsigned VALID_PERIODS = 4,
    parameter logic [1:0]  INIT_WIDTH    = 2'b00
) (
    input  logic       Bit_Rate,
    input  logic       Rst,
    input  logic       Enable,
    input  logic [1:0] Width_Sel,
    output logic       Bit_Rate_10,
    output logic       PCLK,
    output logic       Clk_Valid,
    output logic [1:0] Width_Act
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PARKED = 1'b1
    } state_e;

    localparam logic [5:0] CNT_LAST  = 6'd39;
    localparam logic [3:0] VALID_CNT = 4'(VALID_PERIODS);

    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] width_act_q, width_act_d;
    logic [3:0] stable_q, stable_d;
    logic       live_q, live_d;
    logic       br10_q, br10_d;
    logic       pclk_q, pclk_d;
    logic       valid_q, valid_d;
    logic       wrap_s;
    logic       park_s;
    logic       change_s;

    // Phase within a 10-cycle symbol period for a 0..39 frame position.
    function automatic logic [3:0] mod10(input logic [5:0] c);
        logic [5:0] r;
        if (c >= 6'd30) begin
            r = c - 6'd30;
        end else if (c >= 6'd20) begin
            r = c - 6'd20;
        end else if (c >= 6'd10) begin
            r = c - 6'd10;
        end else begin
            r = c;
        end
        return r[3:0];
    endfunction

    // PCLK level at a frame position for a given ratio code (high in first half of each period).
    function automatic logic pclk_level(input logic [5:0] c, input logic [1:0] w);
        logic lvl;
        case (w)
            2'b00:   lvl = (mod10(c) < 4'd5);
            2'b01:   lvl = (c < 6'd10) || ((c >= 6'd20) && (c < 6'd30));
            2'b10:   lvl = (c < 6'd20);
            default: lvl = (mod10(c) < 4'd5);
        endcase
        return lvl;
    endfunction

    // Next-state logic: frame counter, park/restart decisions, ratio switch and output levels.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = Width_Sel;
        width_act_d = width_act_q;
        stable_d    = stable_q;
        live_d      = live_q;
        br10_d      = 1'b0;
        pclk_d      = 1'b0;
        valid_d     = 1'b0;
        wrap_s      = 1'b0;
        park_s      = 1'b0;
        change_s    = (sel_q != width_act_q) && (sel_q != 2'b11);

        case (state_q)
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    if (Enable) begin
                        wrap_s = 1'b1;
                    end else begin
                        park_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            ST_PARKED: begin
                if (Enable) begin
                    wrap_s = 1'b1;
                end else begin
                    park_s = 1'b1;
                end
            end
            default: begin
                park_s = 1'b1;
            end
        endcase

        if (park_s) begin
            state_d  = ST_PARKED;
            cnt_d    = CNT_LAST;
            stable_d = 4'd0;
            live_d   = 1'b0;
        end else if (wrap_s) begin
            state_d = ST_RUN;
            cnt_d   = 6'd0;
            live_d  = 1'b1;
            if (change_s) begin
                width_act_d = sel_q;
                stable_d    = 4'd0;
            end else if (live_q && (stable_q < VALID_CNT)) begin
                // Start-up wraps do not close a frame, so only count when running.
                stable_d = stable_q + 4'd1;
            end else begin
                stable_d = stable_q;
            end
        end else begin
            state_d = state_q;
        end

        if (park_s) begin
            br10_d  = 1'b0;
            pclk_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            br10_d  = (mod10(cnt_d) < 4'd5);
            pclk_d  = pclk_level(cnt_d, width_act_d);
            valid_d = (stable_d == VALID_CNT);
        end
    end

    // State and output registers; outputs come straight from flops so they are glitch-free.
    always_ff @(posedge Bit_Rate or posedge Rst) begin
        if (Rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= CNT_LAST;
            sel_q       <= INIT_WIDTH;
            width_act_q <= INIT_WIDTH;
            stable_q    <= 4'd0;
            live_q      <= 1'b0;
            br10_q      <= 1'b0;
            pclk_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            width_act_q <= width_act_d;
            stable_q    <= stable_d;
            live_q      <= live_d;
            br10_q      <= br10_d;
            pclk_q      <= pclk_d;
            valid_q     <= valid_d;
        end
    end

    assign Bit_Rate_10 = br10_q;
    assign PCLK        = pclk_q;
    assign Clk_Valid   = valid_q;
    assign Width_Act   = width_act_q;

endmodule
